// File: rtl/e203_irq_stim_mon.sv
// e203_irq_stim_mon: pseudo-random interrupt stimulus and tohost-based test-end monitor for e203 self-test
module e203_irq_stim_mon #(
    parameter int          PC_W       = 32,
    parameter int          NUM_IRQ    = 3,
    parameter int          DLY_MIN    = 1,
    parameter int          DLY_MASK_W = 10,
    parameter int          END_CNT    = 8,
    parameter int          STOP_CNT   = 32,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmt_valid,
    input  logic [PC_W-1:0]         cmt_pc,
    input  logic                    ex_valid,
    input  logic                    ex_ready,
    input  logic [PC_W-1:0]         arm_pc,
    input  logic [PC_W-1:0]         tohost_pc,
    input  logic [NUM_IRQ*PC_W-1:0] ack_pc,
    input  logic [NUM_IRQ-1:0]      irq_en,
    output logic [NUM_IRQ-1:0]      irq_o,
    output logic                    armed,
    output logic [31:0]             tohost_cnt,
    output logic [31:0]             first_tohost_cycle,
    output logic [31:0]             cycle_cnt,
    output logic [31:0]             valid_ir_cnt,
    output logic                    stopped,
    output logic                    done
);
    // delay counter holds DLY_MIN plus the full random span, so a large DLY_MIN never truncates
    localparam int          DW      = $clog2(DLY_MIN + (1 << DLY_MASK_W));
    localparam logic [15:0] RND_MSK = 16'((32'd1 << DLY_MASK_W) - 32'd1);
    typedef enum logic [1:0] {IDLE, WAIT, ASSERT} st_t;
    logic hit_arm, hit_tohost, ended;
    assign hit_arm    = cmt_valid & (cmt_pc == arm_pc);
    assign hit_tohost = cmt_valid & (cmt_pc == tohost_pc);
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt          <= '0;
            tohost_cnt         <= '0;
            first_tohost_cycle <= '0;
            valid_ir_cnt       <= '0;
            armed              <= 1'b0;
            stopped            <= 1'b0;
            done               <= 1'b0;
            ended              <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            armed     <= armed | hit_arm;
            stopped   <= tohost_cnt > 32'(STOP_CNT);
            done      <= done | ((tohost_cnt >= 32'(END_CNT)) & ~|irq_o);
            if (hit_tohost & ~&tohost_cnt)
                tohost_cnt <= tohost_cnt + 32'd1;
            if (hit_tohost & ~ended) begin
                first_tohost_cycle <= cycle_cnt;
                ended              <= 1'b1;
            end
            if (ex_valid & ex_ready & ~ended)
                valid_ir_cnt <= valid_ir_cnt + 32'd1;
        end
    end
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
        localparam logic [15:0] CH_SEED = SEED ^ 16'((i + 1) << 8);
        st_t           st, st_nxt;
        logic [DW-1:0] dly, dly_nxt, dly_ld;
        logic [15:0]   lfsr;
        logic          hit_ack;
        assign hit_ack = cmt_valid & (cmt_pc == ack_pc[i*PC_W +: PC_W]);
        assign dly_ld  = DW'(DLY_MIN) + DW'(lfsr & RND_MSK);
        always_ff @(posedge clk) begin
            if (rst) begin
                st   <= IDLE;
                dly  <= '0;
                lfsr <= CH_SEED;
            end else begin
                st   <= st_nxt;
                dly  <= dly_nxt;
                lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            end
        end
        // an asserted line ignores enable and stop; only its handler commit releases it
        always_comb begin
            st_nxt  = st;
            dly_nxt = dly;
            case (st)
                IDLE: if (armed & irq_en[i] & ~stopped) begin
                    st_nxt  = WAIT;
                    dly_nxt = dly_ld;
                end
                WAIT: begin
                    st_nxt  = (~irq_en[i] | stopped) ? IDLE : (dly == DW'(1)) ? ASSERT : WAIT;
                    dly_nxt = dly - DW'(1);
                end
                ASSERT: if (hit_ack) begin
                    st_nxt  = stopped ? IDLE : WAIT;
                    dly_nxt = dly_ld;
                end
                default: st_nxt = IDLE;
            endcase
        end
        assign irq_o[i] = (st == ASSERT);
    end
endmodule
